// File: rtl/idct_pkg.sv
// Shared constants, state encoding and arithmetic helpers for the 4x4 inverse DCT.
package idct_pkg;

    localparam int unsigned COEF_W = 10;
    localparam int unsigned PIX_W  = 8;
    localparam int unsigned MID_W  = 12;
    localparam int unsigned SHIFT  = 7;
    localparam int unsigned OP_W   = MID_W;  // mac operand width, covers coef, T and C
    localparam int unsigned ACC_W  = 26;     // full-precision dot-product width

    localparam logic signed [7:0] C_MAT [4][4] = '{
        '{8'sd64,  8'sd64,  8'sd64,  8'sd64},
        '{8'sd83,  8'sd34, -8'sd34, -8'sd83},
        '{8'sd64, -8'sd64, -8'sd64,  8'sd64},
        '{8'sd34, -8'sd83,  8'sd83, -8'sd34}
    };

    typedef enum logic [2:0] {
        StIdle,
        StInput,
        StCalc1,
        StCalc2,
        StOutput
    } state_e;

    localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1 << (SHIFT - 1));
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << (PIX_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] PIX_MIN = -ACC_W'(1 << (PIX_W - 1));

    // Round-half-up then floor shift, matching the forward transform.
    function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] x);
        return (x + RND) >>> SHIFT;
    endfunction

    function automatic logic signed [PIX_W-1:0] sat8(input logic signed [ACC_W-1:0] x);
        if (x > PIX_MAX) begin
            return PIX_W'(PIX_MAX);
        end else if (x < PIX_MIN) begin
            return PIX_W'(PIX_MIN);
        end
        return PIX_W'(x);
    endfunction

endpackage

// File: rtl/idct4x4_if.sv
// Coefficient-in / pixel-out streaming bus of the inverse DCT.
interface idct4x4_if;
    import idct_pkg::*;

    logic                     in_valid;
    logic signed [COEF_W-1:0] in_data;
    logic                     out_valid;
    logic signed [PIX_W-1:0]  out_data;

    modport master (
        output in_valid,
        output in_data,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/idct_row_mac.sv
// Four parallel 4-term signed dot products: dot[j] = sum_k a[k] * b[k][j].
module idct_row_mac
    import idct_pkg::*;
(
    input  logic signed [OP_W-1:0]  a   [4],
    input  logic signed [OP_W-1:0]  b   [4][4],
    output logic signed [ACC_W-1:0] dot [4]
);

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            dot[j] = '0;
            for (int k = 0; k < 4; k++) begin
                dot[j] = dot[j] + ACC_W'(a[k]) * ACC_W'(b[k][j]);
            end
        end
    end

endmodule

// File: rtl/idct4x4.sv
// Serial-in/serial-out 4x4 inverse DCT, X = C^T * Y * C with rounding between passes.
module idct4x4
    import idct_pkg::*;
(
    input logic       clk,
    input logic       rst_n,
    idct4x4_if.slave  bus
);

    state_e                   state;
    logic [3:0]               in_cnt;
    logic [1:0]               row_cnt;
    logic [3:0]               out_cnt;
    logic signed [COEF_W-1:0] y_buf [4][4];
    logic signed [MID_W-1:0]  t_buf [4][4];
    logic signed [PIX_W-1:0]  x_buf [4][4];

    logic signed [OP_W-1:0]   mac_a   [4];
    logic signed [OP_W-1:0]   mac_b   [4][4];
    logic signed [ACC_W-1:0]  mac_dot [4];

    // Pass 1 feeds column row_cnt of C against Y; pass 2 feeds row row_cnt of T against C.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            mac_a[k] = '0;
            for (int j = 0; j < 4; j++) begin
                mac_b[k][j] = '0;
            end
        end
        if (state == StCalc1) begin
            for (int k = 0; k < 4; k++) begin
                mac_a[k] = OP_W'(C_MAT[k][row_cnt]);
                for (int j = 0; j < 4; j++) begin
                    mac_b[k][j] = OP_W'(y_buf[k][j]);
                end
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                mac_a[k] = t_buf[row_cnt][k];
                for (int j = 0; j < 4; j++) begin
                    mac_b[k][j] = OP_W'(C_MAT[k][j]);
                end
            end
        end
    end

    idct_row_mac u_mac (
        .a   (mac_a),
        .b   (mac_b),
        .dot (mac_dot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= StIdle;
            in_cnt        <= '0;
            row_cnt       <= '0;
            out_cnt       <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    y_buf[r][c] <= '0;
                    t_buf[r][c] <= '0;
                    x_buf[r][c] <= '0;
                end
            end
        end else begin
            unique case (state)
                StIdle: begin
                    bus.out_valid <= 1'b0;
                    bus.out_data  <= '0;
                    if (bus.in_valid) begin
                        y_buf[0][0] <= bus.in_data;
                        in_cnt      <= 4'd1;
                        state       <= StInput;
                    end
                end
                StInput: begin
                    if (bus.in_valid) begin
                        y_buf[in_cnt[3:2]][in_cnt[1:0]] <= bus.in_data;
                        if (in_cnt == 4'd15) begin
                            in_cnt  <= '0;
                            row_cnt <= '0;
                            state   <= StCalc1;
                        end else begin
                            in_cnt <= in_cnt + 4'd1;
                        end
                    end else begin
                        // Short frame: drop what was collected.
                        in_cnt <= '0;
                        state  <= StIdle;
                    end
                end
                StCalc1: begin
                    for (int j = 0; j < 4; j++) begin
                        t_buf[row_cnt][j] <= MID_W'(round_shift(mac_dot[j]));
                    end
                    row_cnt <= row_cnt + 2'd1;
                    if (row_cnt == 2'd3) begin
                        state <= StCalc2;
                    end
                end
                StCalc2: begin
                    for (int j = 0; j < 4; j++) begin
                        x_buf[row_cnt][j] <= sat8(round_shift(mac_dot[j]));
                    end
                    row_cnt <= row_cnt + 2'd1;
                    if (row_cnt == 2'd3) begin
                        out_cnt <= '0;
                        state   <= StOutput;
                    end
                end
                StOutput: begin
                    bus.out_valid <= 1'b1;
                    bus.out_data  <= x_buf[out_cnt[3:2]][out_cnt[1:0]];
                    out_cnt       <= out_cnt + 4'd1;
                    if (out_cnt == 4'd15) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_idct4x4.sv
// Self-checking bench for idct4x4: directed vectors, abort, mid-output reset, random frames.
module tb_idct4x4;

    logic clk = 1'b0;
    logic rst_n;

    idct4x4_if bus ();

    idct4x4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int cm [4][4] = '{'{64, 64, 64, 64}, '{83, 34, -34, -83},
                      '{64, -64, -64, 64}, '{34, -83, 83, -34}};

    int y_cur [16];
    int x_exp [16];

    typedef struct packed {
        int pos;
        int val;
        int r0;
        int r1;
        int r2;
        int r3;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain matrix arithmetic with floor rounding and clamping.
    task automatic ref_model();
        int t [16];
        int s;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int k = 0; k < 4; k++) s += cm[k][i] * y_cur[k*4+j];
                t[i*4+j] = (s + 64) >>> 7;
            end
        end
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int k = 0; k < 4; k++) s += t[i*4+k] * cm[k][j];
                s = (s + 64) >>> 7;
                if (s > 127) s = 127;
                if (s < -128) s = -128;
                x_exp[i*4+j] = s;
            end
        end
    endtask

    task automatic send_samples(input int count);
        for (int n = 0; n < count; n++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 10'(y_cur[n]);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    // e counts posedges after the one that captured the 16th sample.
    task automatic run_frame(input string tag);
        int exp_v;
        send_samples(16);
        for (int e = 0; e <= 26; e++) begin
            if (e > 0) @(negedge clk);
            exp_v = (e >= 9 && e <= 24) ? 1 : 0;
            check($sformatf("%s valid e%0d", tag, e), int'(bus.out_valid), exp_v);
            check($sformatf("%s data e%0d", tag, e), int'(bus.out_data),
                  (exp_v != 0) ? x_exp[e-9] : 0);
        end
    endtask

    task automatic load_vec(input vec_t v);
        for (int n = 0; n < 16; n++) y_cur[n] = 0;
        y_cur[v.pos] = v.val;
        for (int n = 0; n < 16; n++) begin
            case (n / 4)
                0:       x_exp[n] = v.r0;
                1:       x_exp[n] = v.r1;
                2:       x_exp[n] = v.r2;
                default: x_exp[n] = v.r3;
            endcase
        end
    endtask

    initial begin
        int highs;

        tbl[0] = '{pos: 0, val: 0,    r0: 0,    r1: 0,    r2: 0,    r3: 0};
        tbl[1] = '{pos: 0, val: 64,   r0: 16,   r1: 16,   r2: 16,   r3: 16};
        tbl[2] = '{pos: 4, val: 128,  r0: 42,   r1: 17,   r2: -17,  r3: -41};
        tbl[3] = '{pos: 0, val: 511,  r0: 127,  r1: 127,  r2: 127,  r3: 127};
        tbl[4] = '{pos: 0, val: -512, r0: -128, r1: -128, r2: -128, r3: -128};

        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(negedge clk);
        check("reset out_valid", int'(bus.out_valid), 0);
        check("reset out_data", int'(bus.out_data), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            load_vec(tbl[v]);
            run_frame($sformatf("vec%0d", v));
        end

        // Short frame of 7 samples must produce nothing.
        for (int n = 0; n < 16; n++) y_cur[n] = 64;
        send_samples(7);
        highs = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.out_valid) highs++;
        end
        check("abort no output", highs, 0);
        load_vec(tbl[1]);
        run_frame("after abort");

        // Reset while streaming out.
        for (int n = 0; n < 16; n++) y_cur[n] = int'($urandom_range(0, 1023)) - 512;
        ref_model();
        send_samples(16);
        repeat (13) @(negedge clk);
        check("pre-reset valid", int'(bus.out_valid), 1);
        check("pre-reset data", int'(bus.out_data), x_exp[4]);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid reset out_valid", int'(bus.out_valid), 0);
        check("mid reset out_data", int'(bus.out_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        highs = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.out_valid) highs++;
        end
        check("frame lost after reset", highs, 0);

        for (int f = 0; f < 200; f++) begin
            for (int n = 0; n < 16; n++) begin
                if (f % 8 == 0) y_cur[n] = ($urandom_range(0, 1) != 0) ? 511 : -512;
                else            y_cur[n] = int'($urandom_range(0, 1023)) - 512;
            end
            ref_model();
            run_frame($sformatf("rand%0d", f));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/idct4x4.md
Name: idct4x4

Overview:
- Inverse 4x4 DCT; the decode-side counterpart of the team's forward 4x4 DCT block.
- Accepts 16 signed 10-bit coefficients serially in row-major order.
- Reconstructs X = C^T * Y * C using the same Q7 coefficient matrix C, with rounding between the two passes.
- Streams 16 signed 8-bit saturated pixels out serially.
- Sits after coefficient dequantisation, feeding the pixel reconstruction path.

Parameters:
- COEF_W, 10, input coefficient width (signed)
- PIX_W, 8, output pixel width (signed)
- MID_W, 12, intermediate T element width after pass-1 rounding (signed)
- SHIFT, 7, rounding right-shift applied after each pass (C is Q7)

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  high for 16 consecutive cycles per frame
- in_data  input  COEF_W  signed coefficient Y[r][c], row-major (r = cnt[3:2], c = cnt[1:0])
- out_valid  output  1  high for 16 consecutive cycles per frame
- out_data  output  PIX_W  signed pixel X[r][c], row-major; 0 when out_valid is low

Behaviour:
- Clock and reset: clk is the clock; rst_n is the reset, asynchronous, active-low.
- Reset values: out_valid=0, out_data=0, state=IDLE, counters 0, all buffers 0.
- Coefficient matrix C (signed 8-bit, row-major):
  - row 0: 64, 64, 64, 64
  - row 1: 83, 34, -34, -83
  - row 2: 64, -64, -64, 64
  - row 3: 34, -83, 83, -34
- Pass 1 (CALC1): T[i][j] = sum_k C[k][i]*Y[k][j].
  - Full-precision sum, at least 20 bits.
  - Then T = (sum + 64) >>> 7 (arithmetic shift, i.e. floor), stored in MID_W bits.
  - No overflow is possible for 10-bit inputs.
- Pass 2 (CALC2): X[i][j] = sum_k T[i][k]*C[k][j].
  - Full-precision sum, at least 21 bits.
  - Then (sum + 64) >>> 7, saturated to [-128, 127].
- FSM states: IDLE, INPUT, CALC1, CALC2, OUTPUT.
  - IDLE -> INPUT when in_valid=1. That cycle's sample is stored as index 0.
  - INPUT: stores in_data at in_cnt, in_cnt increments.
    - When in_cnt==15 with in_valid=1: go to CALC1.
    - If in_valid=0 before 16 samples: go to IDLE. The partial frame is discarded, in_cnt cleared, no output.
  - CALC1: 4 cycles, one row i of T per cycle (4 parallel dot products). Then go to CALC2.
  - CALC2: 4 cycles, one row i of X per cycle. Then go to OUTPUT.
  - OUTPUT: 16 cycles. out_valid/out_data are registered from X[out_cnt[3:2]][out_cnt[1:0]]. After out_cnt==15, go to IDLE.
- Latency: take the edge that captures the 16th input as edge 0.
  - out_valid is 1 from edge 9 through edge 24, carrying X[0][0]..X[3][3].
  - out_valid is 0 from edge 25.
- in_valid while in CALC1/CALC2/OUTPUT: ignored, and the sample is dropped. The protocol forbids it.
  - A new frame is accepted from the cycle after the FSM has returned to IDLE.
- Back-to-back frames:
  - Minimum gap between the last in_valid of one frame and the first of the next is 26 cycles.
  - A frame that starts in IDLE while out_valid from the previous frame is still low is processed normally.
- Reset mid-operation: all state clears immediately. out_valid drops asynchronously, and the frame is lost.

Decomposition:
- Package idct_pkg holds:
  - the C matrix as a localparam array;
  - width constants COEF_W, MID_W, PIX_W, SHIFT;
  - a state enum typedef;
  - a round_shift function;
  - a sat8 function.
- Sub-module idct_row_mac:
  - combinational;
  - computes four 4-term signed dot products from a 4-element operand vector and a 4x4 coefficient operand;
  - instantiated once and shared by CALC1 and CALC2 through an operand mux.

Test Plan:
- All-zero frame -> 16 outputs of 0, out_valid high exactly 16 cycles starting at edge 9.
- Y[0][0]=64, rest 0 -> all 16 outputs = 16.
- Y[1][0]=128, rest 0 -> rows 0..3 = 42,42,42,42 / 17,17,17,17 / -17,-17,-17,-17 / -41,-41,-41,-41.
- Saturation:
  - Y[0][0]=511, rest 0 -> all outputs 127 (pre-sat 128).
  - Y[0][0]=-512, rest 0 -> all outputs -128.
- Abort: in_valid low after 7 samples -> no out_valid; the following full DC=64 frame -> all outputs 16.
- rst_n pulsed during OUTPUT at out_cnt=5 -> out_valid and out_data are 0 at once; the next frame is correct, checked against a reference model over 200 random frames.
